zero_group_detect_pipe: RTL and testbench

Parametrised, pipelined successor of the two-group zero-detect function used in the PLA benchmark set. An input word is split into a LO group, a HI group and ignored PAD bits. A selectable mode decides which pattern of "group all-zero / group non-zero" counts as a hit, and the per-word result comes out through a 2-stage valid/ready pipeline. An optional saturating counter tallies hits. The block sits between a benchmark stimulus source and a result sink, and replaces the fixed 10-input, 1-output combinational cell.

---
 rtl/zero_group_detect_pipe.sv | 126 ++++++++++++
 tb/tb_zero_group_detect_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/zero_group_detect_pipe.sv
// Two-group zero detector with a selectable hit rule and a 2-stage valid/ready pipeline.
// Define ZGD_HITCNT_EN to add the saturating hit counter and its hit_cnt port.
module zero_group_detect_pipe #(
    parameter int LO_W  = 4,
    parameter int HI_W  = 4,
    parameter int PAD_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LO_W+HI_W+PAD_W-1:0]  in_data,
    input  logic [1:0]                  in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_y,
    output logic                        out_lo_nz,
    output logic                        out_hi_nz,
    input  logic                        cnt_clr
`ifdef ZGD_HITCNT_EN
    ,
    output logic [CNT_W-1:0]            hit_cnt
`endif
);

    logic       s1_v_q;
    logic       s1_lo_nz_q;
    logic       s1_hi_nz_q;
    logic [1:0] s1_mode_q;

    logic out_valid_q;
    logic out_y_q;
    logic out_lo_nz_q;
    logic out_hi_nz_q;

    logic stage2Load;
    logic stage1Load;
    logic s1_y_d;

    // in_ready follows out_ready combinationally; there is no skid buffer
    assign stage2Load = ~out_valid_q | out_ready;
    assign stage1Load = ~s1_v_q | stage2Load;
    assign in_ready   = stage1Load;

    always_comb begin
        s1_y_d = 1'b0;
        case (s1_mode_q)
            2'd0:    s1_y_d =  s1_lo_nz_q & ~s1_hi_nz_q;
            2'd1:    s1_y_d = ~s1_lo_nz_q &  s1_hi_nz_q;
            2'd2:    s1_y_d = ~s1_lo_nz_q & ~s1_hi_nz_q;
            default: s1_y_d =  s1_lo_nz_q &  s1_hi_nz_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_lo_nz_q <= 1'b0;
            s1_hi_nz_q <= 1'b0;
            s1_mode_q  <= 2'd0;
        end else if (stage1Load) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_lo_nz_q <= |in_data[LO_W-1:0];
                s1_hi_nz_q <= |in_data[LO_W+HI_W-1:LO_W];
                s1_mode_q  <= in_mode;
            end
        end
    end

    // Payload only moves with valid data, so a stalled or bubbled stage keeps its last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_lo_nz_q <= 1'b0;
            out_hi_nz_q <= 1'b0;
        end else if (stage2Load) begin
            out_valid_q <= s1_v_q;
            if (s1_v_q) begin
                out_y_q     <= s1_y_d;
                out_lo_nz_q <= s1_lo_nz_q;
                out_hi_nz_q <= s1_hi_nz_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_lo_nz = out_lo_nz_q;
    assign out_hi_nz = out_hi_nz_q;

`ifdef ZGD_HITCNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;
    logic             unused_pad;

    assign unused_pad = ^in_data;

    // Clear has priority over a coincident increment
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d = '0;
        end else if (out_valid_q && out_ready && out_y_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    logic [CNT_W:0] unused_sink;

    assign unused_sink = {{CNT_W{1'b0}}, ^{in_data, cnt_clr}};
`endif

endmodule

// File: tb/tb_zero_group_detect_pipe.sv
// Scoreboard bench for zero_group_detect_pipe; counter checks run when ZGD_HITCNT_EN is defined.
module tb_zero_group_detect_pipe;

    localparam int W     = 10;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic         out_y;
    logic         out_lo_nz;
    logic         out_hi_nz;
    logic         cnt_clr;
`ifdef ZGD_HITCNT_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    zero_group_detect_pipe #(
        .LO_W (4),
        .HI_W (4),
        .PAD_W(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_lo_nz(out_lo_nz),
        .out_hi_nz(out_hi_nz),
        .cnt_clr  (cnt_clr)
`ifdef ZGD_HITCNT_EN
        ,
        .hit_cnt  (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] expQ[$];
    int         cycQ[$];
    int         cycleNo     = 0;
    int         cntModel    = 0;
    int         outCount    = 0;
    logic       checkLat    = 1'b0;
    logic       checkCnt    = 1'b0;
    logic       inReadySeen = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: returns {y, lo_nz, hi_nz}
    function automatic logic [2:0] refModel(input logic [W-1:0] d, input logic [1:0] m);
        logic lo, hi, y;
        lo = (d[3:0] != 4'h0);
        hi = (d[7:4] != 4'h0);
        case (m)
            2'd0: y = lo && !hi;
            2'd1: y = !lo && hi;
            2'd2: y = !lo && !hi;
            default: y = lo && hi;
        endcase
        return {y, lo, hi};
    endfunction

    // One clock cycle: drive at negedge, observe handshakes just after, then cross the posedge
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                                 input logic r, input logic c);
        logic [2:0] e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = r;
        cnt_clr   = c;
        #1;
        inReadySeen = in_ready;
        if (in_valid && in_ready) begin
            expQ.push_back(refModel(d, m));
            cycQ.push_back(cycleNo);
        end
        if (out_valid && out_ready) begin
            outCount++;
            if (expQ.size() == 0) begin
                checkOutput("spurious_out", 32'(out_valid), 32'd0);
                if (c) cntModel = 0;
            end else begin
                e = expQ.pop_front();
                checkOutput("result", 32'({out_y, out_lo_nz, out_hi_nz}), 32'(e));
                if (checkLat) checkOutput("latency", 32'(cycleNo - cycQ[0]), 32'd2);
                void'(cycQ.pop_front());
                if (c) cntModel = 0;
                else if (e[2] && cntModel < CMAX) cntModel++;
            end
        end else if (c) begin
            cntModel = 0;
        end
        @(posedge clk);
        cycleNo++;
        #1;
`ifdef ZGD_HITCNT_EN
        if (checkCnt) checkOutput("hit_cnt", 32'(hit_cnt), 32'(cntModel));
`endif
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b0);
    endtask

    logic [W-1:0] t1Data[4] = '{10'h001, 10'h011, 10'h000, 10'h300};
    logic [W-1:0] wordsA[3] = '{10'h001, 10'h002, 10'h003};
    int           sent;
    int           budget;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_payload", 32'({out_y, out_lo_nz, out_hi_nz}), 32'd0);
`ifdef ZGD_HITCNT_EN
        checkOutput("reset_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] legacy mode 0");
        checkLat = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, t1Data[i], 2'd0, 1'b1, 1'b0);
        drain(3);
        checkLat = 1'b0;
        checkOutput("t1_drained", 32'(expQ.size()), 32'd0);
        checkOutput("t1_y_last", 32'(out_y), 32'd0);

        $display("[TB] modes 1/2/3");
        for (int m = 0; m < 4; m++) applyStimulus(1'b1, 10'h010, 2'(m), 1'b1, 1'b0);
        for (int m = 0; m < 4; m++) applyStimulus(1'b1, 10'h0FF, 2'(m), 1'b1, 1'b0);
        drain(3);

        $display("[TB] backpressure");
        applyStimulus(1'b1, wordsA[0], 2'd0, 1'b0, 1'b0);
        checkOutput("bp_accept_A", 32'(inReadySeen), 32'd1);
        applyStimulus(1'b1, wordsA[1], 2'd0, 1'b0, 1'b0);
        checkOutput("bp_accept_B", 32'(inReadySeen), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, wordsA[2], 2'd0, 1'b0, 1'b0);
            checkOutput("bp_in_ready_low", 32'(inReadySeen), 32'd0);
            checkOutput("bp_hold_A", 32'({out_valid, out_y, out_lo_nz, out_hi_nz}), 32'b1110);
        end
        applyStimulus(1'b1, wordsA[2], 2'd0, 1'b1, 1'b0);
        checkOutput("bp_accept_C_on_release", 32'(inReadySeen), 32'd1);
        drain(4);
        checkOutput("bp_drained", 32'(expQ.size()), 32'd0);

`ifdef ZGD_HITCNT_EN
        $display("[TB] counter saturation");
        checkCnt = 1'b1;
        applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10'h001, 2'd0, 1'b1, 1'b0);
        drain(2);
        checkOutput("sat_value", 32'(hit_cnt), 32'd3);
        applyStimulus(1'b1, 10'h001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 2'd0, 1'b1, 1'b1);
        checkOutput("clr_wins", 32'(hit_cnt), 32'd0);
        checkCnt = 1'b0;
        applyStimulus(1'b1, 10'h001, 2'd0, 1'b1, 1'b0);
        drain(3);
        checkOutput("cnt_after_clr", 32'(hit_cnt), 32'd1);
`endif

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 10'h001, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h002, 2'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
`ifdef ZGD_HITCNT_EN
        checkOutput("midreset_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
        expQ.delete();
        cycQ.delete();
        cntModel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        outCount = 0;
        drain(4);
        checkOutput("midreset_no_stale", 32'(outCount), 32'd0);

        $display("[TB] random traffic");
        sent = 0;
        budget = 0;
        outCount = 0;
        while (sent < 10000 && budget < 60000) begin
            logic v;
            v = ($urandom_range(0, 9) < 7);
            applyStimulus(v, W'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), 1'b0);
            if (v && inReadySeen) sent++;
            budget++;
        end
        if (sent < 10000) checkOutput("random_budget", 32'(sent), 32'd10000);
        drain(4);
        checkOutput("random_all_out", 32'(outCount), 32'(sent));
        checkOutput("random_queue_empty", 32'(expQ.size()), 32'd0);
`ifdef ZGD_HITCNT_EN
        checkOutput("random_hit_cnt", 32'(hit_cnt), 32'(cntModel));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
